// File: rtl/cam_match_array.sv
// Tagged entry store with per-entry valid bits and a parallel key compare.
// Produces a registered match vector for the downstream CAM priority encoder.
module cam_match_array #(
    parameter int ADDR_WIDTH = 8,
    parameter int DEPTH      = 1 << ADDR_WIDTH,
    parameter int DATA_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  inv_en,
    input  logic [ADDR_WIDTH-1:0] inv_addr,
    input  logic                  flush,
    input  logic                  search_en,
    input  logic [DATA_WIDTH-1:0] search_key,
    output logic                  match_valid,
    output logic [DEPTH-1:0]      match_vec,
    output logic [ADDR_WIDTH:0]   entry_count,
    output logic                  full
);

    localparam logic [ADDR_WIDTH:0] FULL_CNT = (ADDR_WIDTH+1)'(DEPTH);

    logic [DATA_WIDTH-1:0] data_r [DEPTH];
    logic [DEPTH-1:0]      valid_r;
    logic [DEPTH-1:0]      valid_nxt_s;
    logic [DEPTH-1:0]      cmp_s;
    logic                  wr_new_s;
    logic                  inv_hit_s;
    logic [ADDR_WIDTH:0]   count_r;
    logic [ADDR_WIDTH:0]   count_nxt_s;
    logic                  match_valid_r;
    logic [DEPTH-1:0]      match_vec_r;

    // Parallel compare against the pre-edge table; invalid entries never match.
    always_comb begin
        cmp_s = '0;
        for (int i = 0; i < DEPTH; i++) begin
            cmp_s[i] = valid_r[i] && (data_r[i] == search_key);
        end
    end

    // Next valid bits: flush beats everything, a write beats an invalidate.
    always_comb begin
        valid_nxt_s = valid_r;
        if (flush) begin
            valid_nxt_s = '0;
        end else begin
            if (inv_en) begin
                valid_nxt_s[inv_addr] = 1'b0;
            end else begin
                valid_nxt_s[inv_addr] = valid_r[inv_addr];
            end
            if (wr_en) begin
                valid_nxt_s[wr_addr] = 1'b1;
            end else begin
                valid_nxt_s[wr_addr] = valid_nxt_s[wr_addr];
            end
        end
    end

    // Count tracks only real valid transitions, so it stays within 0..DEPTH.
    always_comb begin
        wr_new_s  = wr_en && !valid_r[wr_addr];
        inv_hit_s = inv_en && valid_r[inv_addr] && !(wr_en && (wr_addr == inv_addr));
        if (flush) begin
            count_nxt_s = '0;
        end else if (wr_new_s && !inv_hit_s) begin
            count_nxt_s = count_r + {{ADDR_WIDTH{1'b0}}, 1'b1};
        end else if (!wr_new_s && inv_hit_s) begin
            count_nxt_s = count_r - {{ADDR_WIDTH{1'b0}}, 1'b1};
        end else begin
            count_nxt_s = count_r;
        end
    end

    // Entry payload storage, deliberately not reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            data_r[wr_addr] <= wr_data;
        end
    end

    // Valid bits and entry count.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            valid_r <= '0;
            count_r <= '0;
        end else begin
            valid_r <= valid_nxt_s;
            count_r <= count_nxt_s;
        end
    end

    // Search result register; an idle cycle clears the vector.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            match_valid_r <= 1'b0;
            match_vec_r   <= '0;
        end else if (search_en) begin
            match_valid_r <= 1'b1;
            match_vec_r   <= cmp_s;
        end else begin
            match_valid_r <= 1'b0;
            match_vec_r   <= '0;
        end
    end

    assign match_valid = match_valid_r;
    assign match_vec   = match_vec_r;
    assign entry_count = count_r;
    assign full        = (count_r == FULL_CNT);

endmodule

// File: tb/tb_cam_match_array.sv
// Directed scoreboard bench for cam_match_array: stimulus pushes expected match
// vectors, a negedge monitor pops them whenever match_valid is presented.
module tb_cam_match_array;

    localparam int AW = 8;
    localparam int DP = 256;
    localparam int DW = 16;

    logic          clk;
    logic          reset_n;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic          inv_en;
    logic [AW-1:0] inv_addr;
    logic          flush;
    logic          search_en;
    logic [DW-1:0] search_key;
    logic          match_valid;
    logic [DP-1:0] match_vec;
    logic [AW:0]   entry_count;
    logic          full;

    int total = 0;
    int bad   = 0;
    logic [DP-1:0] exp_q [$];

    cam_match_array #(.ADDR_WIDTH(AW), .DEPTH(DP), .DATA_WIDTH(DW)) dut (
        .clk(clk), .reset_n(reset_n),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .inv_en(inv_en), .inv_addr(inv_addr), .flush(flush),
        .search_en(search_en), .search_key(search_key),
        .match_valid(match_valid), .match_vec(match_vec),
        .entry_count(entry_count), .full(full)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [DP-1:0] bit_of(input int idx);
        logic [DP-1:0] v;
        v = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

    task automatic check(input string name, input logic [DP-1:0] act, input logic [DP-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One clock of stimulus; inputs change #1 after the rising edge.
    task automatic cyc(input logic we, input int wa, input logic [DW-1:0] wd,
                       input logic ie, input int ia, input logic fl,
                       input logic se, input logic [DW-1:0] sk, input logic [DP-1:0] ev);
        wr_en = we; wr_addr = AW'(wa); wr_data = wd;
        inv_en = ie; inv_addr = AW'(ia); flush = fl;
        search_en = se; search_key = sk;
        if (se) exp_q.push_back(ev);
        @(posedge clk);
        #1;
        wr_en = 1'b0; inv_en = 1'b0; flush = 1'b0; search_en = 1'b0;
    endtask

    task automatic wr(input int a, input logic [DW-1:0] d);
        cyc(1'b1, a, d, 1'b0, 0, 1'b0, 1'b0, 16'h0000, '0);
    endtask

    task automatic srch(input logic [DW-1:0] k, input logic [DP-1:0] ev);
        cyc(1'b0, 0, 16'h0000, 1'b0, 0, 1'b0, 1'b1, k, ev);
    endtask

    task automatic chk_cnt(input string name, input int cnt, input logic f);
        check({name, "_count"}, DP'(entry_count), DP'(cnt));
        check({name, "_full"}, DP'(full), DP'(f));
    endtask

    // Monitor: every presented result must match the oldest queued expectation.
    always @(negedge clk) begin
        if (match_valid) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_result: got match_valid=1 vec=%h expected no result", match_vec);
            end else begin
                check("match_vec", match_vec, exp_q.pop_front());
            end
        end else begin
            check("idle_vec_zero", match_vec, '0);
        end
    end

    initial begin
        reset_n = 1'b0;
        wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        inv_en = 1'b0; inv_addr = '0; flush = 1'b0;
        search_en = 1'b0; search_key = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_valid", DP'(match_valid), '0);
        chk_cnt("reset", 0, 1'b0);
        reset_n = 1'b1;

        // 1: empty table
        srch(16'h0000, '0);
        chk_cnt("t1", 0, 1'b0);

        // 2: duplicate keys
        wr(3, 16'hABCD);
        wr(10, 16'hABCD);
        srch(16'hABCD, bit_of(3) | bit_of(10));
        chk_cnt("t2", 2, 1'b0);

        // 3: a same-cycle write is invisible to the search
        cyc(1'b1, 5, 16'h1234, 1'b0, 0, 1'b0, 1'b1, 16'h1234, '0);
        srch(16'h1234, bit_of(5));
        chk_cnt("t3", 3, 1'b0);

        // 4: write wins over invalidate, then invalidate alone, then net-zero pair
        cyc(1'b1, 3, 16'hABCD, 1'b1, 3, 1'b0, 1'b0, 16'h0000, '0);
        chk_cnt("t4_wr_inv", 3, 1'b0);
        srch(16'hABCD, bit_of(3) | bit_of(10));
        cyc(1'b0, 0, 16'h0000, 1'b1, 3, 1'b0, 1'b0, 16'h0000, '0);
        chk_cnt("t4_inv", 2, 1'b0);
        srch(16'hABCD, bit_of(10));
        cyc(1'b1, 20, 16'hABCD, 1'b1, 10, 1'b0, 1'b0, 16'h0000, '0);
        chk_cnt("t4_pair", 2, 1'b0);
        srch(16'hABCD, bit_of(20));

        // 5: fill, overwrite while full, flush overriding a write
        for (int i = 0; i < DP; i++) wr(i, 16'(i));
        chk_cnt("t5_fill", 256, 1'b1);
        srch(16'h0042, bit_of(66));
        wr(0, 16'h5555);
        chk_cnt("t5_over", 256, 1'b1);
        srch(16'h5555, bit_of(0));
        cyc(1'b1, 7, 16'h7777, 1'b0, 0, 1'b1, 1'b1, 16'h0042, bit_of(66));
        chk_cnt("t5_flush", 0, 1'b0);
        srch(16'h7777, '0);
        srch(16'h0042, '0);

        // 6: async reset while a result is presented
        wr(1, 16'h9999);
        srch(16'h9999, bit_of(1));
        check("t6_pre_valid", DP'(match_valid), DP'(1));
        @(negedge clk);
        #1;
        search_en = 1'b1; search_key = 16'h9999;
        reset_n = 1'b0;
        #1;
        check("t6_rst_valid", DP'(match_valid), '0);
        check("t6_rst_vec", match_vec, '0);
        chk_cnt("t6_rst", 0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        search_en = 1'b0;
        reset_n = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        chk_cnt("t6_post", 0, 1'b0);
        srch(16'h9999, '0);
        repeat (2) @(posedge clk);
        #1;

        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL missing_results: got %0d pending expected 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
